// File: rtl/uart_alu_pkg.sv
// Shared opcodes, FSM states and ALU op select for the UART packet sequencer.
// Optional multiplier support is enabled with UART_ALU_MUL_EN.
package uart_alu_pkg;

   localparam int         HDR_BYTES = 4;
   localparam logic [7:0] OP_ECHO   = 8'hEC;
   localparam logic [7:0] OP_ADD32  = 8'hAD;
   localparam logic [7:0] OP_MUL32  = 8'h88;

   typedef enum logic [3:0] {
      S_OPC,
      S_RSVD,
      S_LEN_LO,
      S_LEN_HI,
      S_E_RX,
      S_E_TX,
      S_ACC,
      S_SEND,
      S_DRAIN
   } state_e;

   typedef enum logic {
      ALU_ADD,
      ALU_MUL
   } alu_op_e;

endpackage

// File: rtl/uart_alu_acc.sv
// Byte-to-word assembler with running add (or multiply, under UART_ALU_MUL_EN)
// accumulator. result_o already includes the word that completes this cycle.
module uart_alu_acc
   import uart_alu_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] byte_i,
   input  logic                  byte_valid_i,
   input  logic                  clear_i,
   input  alu_op_e               op_i,
   output logic                  word_done_o,
   output logic [WORD_WIDTH-1:0] result_o
);

   localparam int BPW  = WORD_WIDTH / DATA_WIDTH;
   localparam int IW   = $clog2(BPW);
   localparam int LO_W = WORD_WIDTH - DATA_WIDTH;

   logic [LO_W-1:0]       lo_q;
   logic [IW-1:0]         idx_q;
   logic                  first_q;
   logic [WORD_WIDTH-1:0] acc_q;
   logic [WORD_WIDTH-1:0] word;
   logic [WORD_WIDTH-1:0] combined;
   logic [WORD_WIDTH-1:0] acc_nxt;

   assign word = {byte_i, lo_q};

   always_comb begin
      word_done_o = byte_valid_i && (idx_q == IW'(BPW - 1));
`ifdef UART_ALU_MUL_EN
      combined = (op_i == ALU_MUL) ? acc_q * word : acc_q + word;
`else
      combined = (op_i == ALU_ADD) ? acc_q + word : '0;
`endif
      acc_nxt  = first_q ? word : combined;
      result_o = word_done_o ? acc_nxt : acc_q;
   end

   // Bytes enter at the top and shift down, so the first byte lands in bits [7:0].
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         lo_q    <= '0;
         idx_q   <= '0;
         first_q <= 1'b1;
         acc_q   <= '0;
      end else if (byte_valid_i) begin
         lo_q  <= {byte_i, lo_q[LO_W-1:DATA_WIDTH]};
         idx_q <= idx_q + 1'b1;
         if (word_done_o) begin
            acc_q   <= acc_nxt;
            first_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Packet sequencer between UART RX and TX streams: parses header, echoes or
// accumulates payload words, returns results. MUL32 opcode needs UART_ALU_MUL_EN.
module uart_alu_ctrl
   import uart_alu_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] rx_tdata_i,
   input  logic                  rx_tvalid_i,
   output logic                  rx_tready_o,
   output logic [DATA_WIDTH-1:0] tx_tdata_o,
   output logic                  tx_tvalid_o,
   input  logic                  tx_tready_i,
   output logic                  busy_o,
   output logic                  err_o,
   output state_e                state_o
);

   localparam int BPW = WORD_WIDTH / DATA_WIDTH;
   localparam int IW  = $clog2(BPW);

   // A byte moves on a stream only in a cycle where valid and ready are both
   // high; valid, once raised, holds its data until that handshake.
   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] opc_q;
   logic [DATA_WIDTH-1:0] len_lo_q;
   logic [15:0]           cnt_q;
   logic [IW-1:0]         idx_q;
   logic [WORD_WIDTH-1:0] tx_sr_q;
   logic                  err_q;

   logic                  rx_hs, tx_hs;
   logic [15:0]           len_w, pay_w;
   logic                  is_echo, is_arith;
   logic                  hdr_err;
   logic                  cnt_dec;
   logic                  acc_done;
   logic [WORD_WIDTH-1:0] acc_result;
   alu_op_e               acc_op;

   assign rx_tready_o = (state_q != S_E_TX) && (state_q != S_SEND);
   assign tx_tvalid_o = (state_q == S_E_TX) || (state_q == S_SEND);
   assign tx_tdata_o  = tx_sr_q[DATA_WIDTH-1:0];
   assign busy_o      = (state_q != S_OPC);
   assign err_o       = err_q;
   assign state_o     = state_q;

   assign rx_hs   = rx_tvalid_i && rx_tready_o;
   assign tx_hs   = tx_tvalid_o && tx_tready_i;
   assign len_w   = {rx_tdata_i, len_lo_q};
   assign pay_w   = len_w - 16'(HDR_BYTES);
   assign is_echo = (opc_q == OP_ECHO);
`ifdef UART_ALU_MUL_EN
   assign is_arith = (opc_q == OP_ADD32) || (opc_q == OP_MUL32);
`else
   assign is_arith = (opc_q == OP_ADD32);
`endif
   assign acc_op  = (opc_q == OP_MUL32) ? ALU_MUL : ALU_ADD;
   assign cnt_dec = rx_hs && ((state_q == S_E_RX) || (state_q == S_ACC) || (state_q == S_DRAIN));

   always_comb begin
      state_d = state_q;
      hdr_err = 1'b0;
      unique case (state_q)
         S_OPC:    if (rx_hs) state_d = S_RSVD;
         S_RSVD:   if (rx_hs) state_d = S_LEN_LO;
         S_LEN_LO: if (rx_hs) state_d = S_LEN_HI;
         S_LEN_HI: begin
            if (rx_hs) begin
               if (len_w < 16'(HDR_BYTES)) begin
                  hdr_err = 1'b1;
                  state_d = S_OPC;
               end else if (pay_w == 16'd0) begin
                  // Empty arithmetic packet still answers with a zero result.
                  if (is_echo)       state_d = S_OPC;
                  else if (is_arith) state_d = S_SEND;
                  else begin
                     hdr_err = 1'b1;
                     state_d = S_OPC;
                  end
               end else if (is_echo) begin
                  state_d = S_E_RX;
               end else if (is_arith && ((pay_w % 16'(BPW)) == 16'd0)) begin
                  state_d = S_ACC;
               end else begin
                  hdr_err = 1'b1;
                  state_d = S_DRAIN;
               end
            end
         end
         S_E_RX:  if (rx_hs) state_d = S_E_TX;
         S_E_TX:  if (tx_hs) state_d = (cnt_q == 16'd0) ? S_OPC : S_E_RX;
         S_ACC:   if (rx_hs && cnt_q == 16'd1) state_d = S_SEND;
         S_SEND:  if (tx_hs && idx_q == IW'(BPW - 1)) state_d = S_OPC;
         S_DRAIN: if (rx_hs && cnt_q == 16'd1) state_d = S_OPC;
         default: state_d = S_OPC;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_OPC;
         opc_q    <= '0;
         len_lo_q <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         tx_sr_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= hdr_err;
         if (state_q == S_OPC && rx_hs)    opc_q    <= rx_tdata_i;
         if (state_q == S_LEN_LO && rx_hs) len_lo_q <= rx_tdata_i;
         if (state_q == S_LEN_HI && rx_hs) cnt_q <= pay_w;
         else if (cnt_dec)                 cnt_q <= cnt_q - 16'd1;
         if (state_q == S_SEND && tx_hs)   idx_q <= idx_q + 1'b1;
         // TX shifter drains to zero after its last byte, so idle data reads 0.
         if (state_q == S_LEN_HI && rx_hs)
            tx_sr_q <= '0;
         else if (state_q == S_E_RX && rx_hs)
            tx_sr_q <= {{(WORD_WIDTH-DATA_WIDTH){1'b0}}, rx_tdata_i};
         else if (state_q == S_ACC && acc_done && cnt_q == 16'd1)
            tx_sr_q <= acc_result;
         else if (tx_hs)
            tx_sr_q <= tx_sr_q >> DATA_WIDTH;
      end
   end

   uart_alu_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORD_WIDTH (WORD_WIDTH)
   ) u_acc (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .byte_i       (rx_tdata_i),
      .byte_valid_i (rx_hs && (state_q == S_ACC)),
      .clear_i      (rx_hs && (state_q == S_LEN_HI)),
      .op_i         (acc_op),
      .word_done_o  (acc_done),
      .result_o     (acc_result)
   );

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: echo, add, malformed, mul (UART_ALU_MUL_EN
// dependent), empty/short packets, TX backpressure and mid-packet reset.
module tb_uart_alu_ctrl;
   import uart_alu_pkg::*;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [7:0] rx_tdata_i = '0;
   logic       rx_tvalid_i = 1'b0;
   logic       rx_tready_o;
   logic [7:0] tx_tdata_o;
   logic       tx_tvalid_o;
   logic       tx_tready_i = 1'b1;
   logic       busy_o;
   logic       err_o;
   state_e     state_o;

   uart_alu_ctrl dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rx_tdata_i  (rx_tdata_i),
      .rx_tvalid_i (rx_tvalid_i),
      .rx_tready_o (rx_tready_o),
      .tx_tdata_o  (tx_tdata_o),
      .tx_tvalid_o (tx_tvalid_o),
      .tx_tready_i (tx_tready_i),
      .busy_o      (busy_o),
      .err_o       (err_o),
      .state_o     (state_o)
   );

   always #5 clk_i = ~clk_i;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;
   int err_cnt  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] pkt_q[$];

   // Inputs only change just after posedge, so negedge sees what the next edge will.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (tx_tvalid_o && tx_tready_i) got_q.push_back(tx_tdata_o);
         if (err_o) err_cnt++;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk_i);
      rx_tdata_i  = b;
      rx_tvalid_i = 1'b1;
      while (!rx_tready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (!rx_tready_o) begin
         chk_cnt++; fail_cnt++;
         $display("FAIL rx_ready_timeout: byte %h never accepted", b);
      end
      @(posedge clk_i);
      #1 rx_tvalid_i = 1'b0;
   endtask

   task automatic send_pkt();
      while (pkt_q.size() > 0) send_byte(pkt_q.pop_front());
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk_i);
      while (busy_o && n < 500) begin
         @(negedge clk_i);
         n++;
      end
      if (busy_o) begin
         chk_cnt++; fail_cnt++;
         $display("FAIL idle_timeout: busy_o still %b", busy_o);
      end
      repeat (2) @(negedge clk_i);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk_cnt++; if (rx_tready_o !== 1'b1) begin fail_cnt++; $display("FAIL reset_rx_tready: got %b exp 1", rx_tready_o); end else pass_cnt++;
      chk_cnt++; if (tx_tvalid_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_tx_tvalid: got %b exp 0", tx_tvalid_o); end else pass_cnt++;
      chk_cnt++; if (tx_tdata_o !== 8'h00) begin fail_cnt++; $display("FAIL reset_tx_tdata: got %h exp 00", tx_tdata_o); end else pass_cnt++;
      chk_cnt++; if (busy_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b exp 0", busy_o); end else pass_cnt++;
      chk_cnt++; if (err_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_err: got %b exp 0", err_o); end else pass_cnt++;
   endtask

   task automatic test_echo();
      int e0 = err_cnt;
      got_q.delete();
      exp_q = '{8'h41, 8'h42, 8'h43};
      pkt_q = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
      send_pkt();
      wait_idle();
      chk_cnt++; if (got_q.size() !== exp_q.size()) begin fail_cnt++; $display("FAIL echo_len: got %0d exp %0d", got_q.size(), exp_q.size()); end else pass_cnt++;
      foreach (exp_q[i]) begin
         chk_cnt++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL echo_byte%0d: exp %h", i, exp_q[i]); end else pass_cnt++;
      end
      chk_cnt++; if (err_cnt - e0 !== 0) begin fail_cnt++; $display("FAIL echo_err: got %0d pulses exp 0", err_cnt - e0); end else pass_cnt++;
      chk_cnt++; if (busy_o !== 1'b0) begin fail_cnt++; $display("FAIL echo_busy: got %b exp 0", busy_o); end else pass_cnt++;
   endtask

   task automatic test_add_wrap();
      got_q.delete();
      exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
      pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      send_pkt();
      wait_idle();
      chk_cnt++; if (got_q.size() !== exp_q.size()) begin fail_cnt++; $display("FAIL add_wrap_len: got %0d exp %0d", got_q.size(), exp_q.size()); end else pass_cnt++;
      foreach (exp_q[i]) begin
         chk_cnt++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL add_wrap_byte%0d: exp %h", i, exp_q[i]); end else pass_cnt++;
      end
   endtask

   task automatic test_add3();
      got_q.delete();
      exp_q = '{8'h06, 8'h00, 8'h00, 8'h00};
      pkt_q = '{8'hAD, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
      send_pkt();
      chk_cnt++; if (tx_tvalid_o !== 1'b1 || tx_tdata_o !== 8'h06) begin fail_cnt++; $display("FAIL add3_latency: got valid %b data %h exp 1 06", tx_tvalid_o, tx_tdata_o); end else pass_cnt++;
      wait_idle();
      chk_cnt++; if (got_q.size() !== exp_q.size()) begin fail_cnt++; $display("FAIL add3_len: got %0d exp %0d", got_q.size(), exp_q.size()); end else pass_cnt++;
      foreach (exp_q[i]) begin
         chk_cnt++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL add3_byte%0d: exp %h", i, exp_q[i]); end else pass_cnt++;
      end
   endtask

   task automatic test_malformed();
      int e0 = err_cnt;
      got_q.delete();
      pkt_q = '{8'hAD, 8'h00, 8'h06, 8'h00};
      send_pkt();
      chk_cnt++; if (err_o !== 1'b1) begin fail_cnt++; $display("FAIL malformed_err_timing: got %b exp 1", err_o); end else pass_cnt++;
      pkt_q = '{8'h11, 8'h22};
      send_pkt();
      wait_idle();
      chk_cnt++; if (err_cnt - e0 !== 1) begin fail_cnt++; $display("FAIL malformed_err_count: got %0d exp 1", err_cnt - e0); end else pass_cnt++;
      chk_cnt++; if (got_q.size() !== 0) begin fail_cnt++; $display("FAIL malformed_no_tx: got %0d bytes exp 0", got_q.size()); end else pass_cnt++;
      pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
      send_pkt();
      wait_idle();
      chk_cnt++; if (got_q.size() !== 1 || got_q[0] !== 8'h5A) begin fail_cnt++; $display("FAIL malformed_recover: got %0d bytes exp one 5a", got_q.size()); end else pass_cnt++;
   endtask

   task automatic test_mul();
      int e0 = err_cnt;
      got_q.delete();
      pkt_q = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
      send_pkt();
      wait_idle();
`ifdef UART_ALU_MUL_EN
      exp_q = '{8'h0F, 8'h00, 8'h00, 8'h00};
      chk_cnt++; if (err_cnt - e0 !== 0) begin fail_cnt++; $display("FAIL mul_err: got %0d exp 0", err_cnt - e0); end else pass_cnt++;
`else
      exp_q.delete();
      chk_cnt++; if (err_cnt - e0 !== 1) begin fail_cnt++; $display("FAIL mul_err: got %0d exp 1", err_cnt - e0); end else pass_cnt++;
`endif
      chk_cnt++; if (got_q.size() !== exp_q.size()) begin fail_cnt++; $display("FAIL mul_len: got %0d exp %0d", got_q.size(), exp_q.size()); end else pass_cnt++;
      foreach (exp_q[i]) begin
         chk_cnt++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL mul_byte%0d: exp %h", i, exp_q[i]); end else pass_cnt++;
      end
   endtask

   task automatic test_boundaries();
      int e0 = err_cnt;
      got_q.delete();
      // Empty ADD answers zero; empty ECHO is silent; LEN=2 is an error.
      exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
      pkt_q = '{8'hAD, 8'h00, 8'h04, 8'h00, 8'hEC, 8'h00, 8'h04, 8'h00};
      send_pkt();
      wait_idle();
      chk_cnt++; if (got_q.size() !== exp_q.size()) begin fail_cnt++; $display("FAIL empty_len: got %0d exp %0d", got_q.size(), exp_q.size()); end else pass_cnt++;
      chk_cnt++; if (err_cnt - e0 !== 0) begin fail_cnt++; $display("FAIL empty_err: got %0d exp 0", err_cnt - e0); end else pass_cnt++;
      pkt_q = '{8'hEC, 8'h00, 8'h02, 8'h00};
      send_pkt();
      wait_idle();
      chk_cnt++; if (err_cnt - e0 !== 1) begin fail_cnt++; $display("FAIL short_len_err: got %0d exp 1", err_cnt - e0); end else pass_cnt++;
      chk_cnt++; if (got_q.size() !== exp_q.size()) begin fail_cnt++; $display("FAIL short_len_tx: got %0d exp %0d", got_q.size(), exp_q.size()); end else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic stable = 1'b1;
      got_q.delete();
      exp_q = '{8'h78, 8'h56, 8'h34, 8'h12};
      tx_tready_i = 1'b0;
      pkt_q = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      send_pkt();
      repeat (20) begin
         @(negedge clk_i);
         if (tx_tvalid_o !== 1'b1 || tx_tdata_o !== 8'h78) stable = 1'b0;
      end
      chk_cnt++; if (stable !== 1'b1) begin fail_cnt++; $display("FAIL bp_stable: last valid %b data %h exp 1 78", tx_tvalid_o, tx_tdata_o); end else pass_cnt++;
      @(posedge clk_i);
      #1 tx_tready_i = 1'b1;
      wait_idle();
      chk_cnt++; if (got_q.size() !== exp_q.size()) begin fail_cnt++; $display("FAIL bp_len: got %0d exp %0d", got_q.size(), exp_q.size()); end else pass_cnt++;
      foreach (exp_q[i]) begin
         chk_cnt++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin fail_cnt++; $display("FAIL bp_byte%0d: exp %h", i, exp_q[i]); end else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      got_q.delete();
      pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00};
      send_pkt();
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk_cnt++; if (state_o !== S_OPC) begin fail_cnt++; $display("FAIL rstmid_state: got %0d exp %0d", state_o, S_OPC); end else pass_cnt++;
      chk_cnt++; if (rx_tready_o !== 1'b1 || tx_tvalid_o !== 1'b0 || tx_tdata_o !== 8'h00 || busy_o !== 1'b0 || err_o !== 1'b0) begin
         fail_cnt++; $display("FAIL rstmid_outputs: rdy %b vld %b data %h busy %b err %b exp 1 0 00 0 0", rx_tready_o, tx_tvalid_o, tx_tdata_o, busy_o, err_o);
      end else pass_cnt++;
      rst_i = 1'b0;
      pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'hA5};
      send_pkt();
      wait_idle();
      chk_cnt++; if (got_q.size() !== 1 || got_q[0] !== 8'hA5) begin fail_cnt++; $display("FAIL rstmid_echo: got %0d bytes exp one a5", got_q.size()); end else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_echo();
      test_add_wrap();
      test_add3();
      test_malformed();
      test_mul();
      test_boundaries();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
